// File: rtl/alu_rr_arbiter_pkg.sv
// Shared definitions for the round-robin ALU arbiter: ALU width and op encoding.
package alu_rr_arbiter_pkg;

  // Native width of the shared ALU; the arbiter's DATA_W must match it.
  localparam int ALU_W = 4;

  // ALUControl encoding understood by the ALU; 3'b100..3'b111 yield zero.
  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011
  } alu_op_e;

endpackage

// File: rtl/alu_rr_arbiter_alu.sv
// Combinational 4-bit ALU: ADD/SUB/AND/OR with a Zero flag, modulo 2^ALU_W.
module alu
  import alu_rr_arbiter_pkg::*;
(
  input  logic [ALU_W-1:0] a_i,
  input  logic [ALU_W-1:0] b_i,
  input  logic [2:0]       op_i,
  output logic [ALU_W-1:0] result_o,
  output logic             zero_o
);

  // Decode the op; unused encodings produce a zero result.
  always_comb begin
    result_o = '0;
    case (op_i)
      OP_ADD:  result_o = a_i + b_i;
      OP_SUB:  result_o = a_i - b_i;
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      default: result_o = '0;
    endcase
    zero_o = (result_o == '0);
  end

endmodule

// File: rtl/alu_rr_arbiter_grant.sv
// Round-robin grant picker: first eligible index starting at ptr, wrapping mod N.
module rr_grant #(
  parameter  int N  = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  eligible_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [PW-1:0] grant_idx_o,
  output logic          grant_any_o
);

  // Scan ptr, ptr+1, ... and take the first eligible requester.
  always_comb begin
    int idx;
    grant_o     = '0;
    grant_idx_o = '0;
    grant_any_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_i) + k) % N;
      if (!grant_any_o && eligible_i[idx]) begin
        grant_o[idx] = 1'b1;
        grant_idx_o  = PW'(idx);
        grant_any_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Shares one ALU among N_REQ requesters with round-robin grant and a
// registered response slot per requester.
module alu_rr_arbiter
  import alu_rr_arbiter_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int DATA_W = ALU_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*DATA_W-1:0]   req_a,
  input  logic [N_REQ*DATA_W-1:0]   req_b,
  input  logic [N_REQ*3-1:0]        req_op,
  output logic [N_REQ-1:0]          rsp_valid,
  input  logic [N_REQ-1:0]          rsp_ready,
  output logic [N_REQ*DATA_W-1:0]   rsp_result,
  output logic [N_REQ-1:0]          rsp_zero
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0]  rr_ptr_q;
  logic [PTR_W-1:0]  rr_ptr_d;
  logic [N_REQ-1:0]  eligible;
  logic [N_REQ-1:0]  grant;
  logic [N_REQ-1:0]  accept;
  logic [PTR_W-1:0]  grant_idx;
  logic              grant_any;
  logic              accept_any;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [2:0]        alu_op;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;

  // A requester may be granted only if its slot is empty or drains this cycle.
  assign eligible = req_valid & (~rsp_valid | rsp_ready);

  rr_grant #(.N(N_REQ)) u_grant (
    .eligible_i  (eligible),
    .ptr_i       (rr_ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .grant_any_o (grant_any)
  );

  // Grant is eligibility-qualified, so ready alone marks an accept; held off in reset.
  assign accept     = rst_n ? grant : '0;
  assign accept_any = rst_n & grant_any;
  assign req_ready  = accept;

  // Steer the granted requester's operands into the ALU; idle inputs are zero.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = '0;
    if (accept_any) begin
      alu_a  = req_a[grant_idx*DATA_W +: DATA_W];
      alu_b  = req_b[grant_idx*DATA_W +: DATA_W];
      alu_op = req_op[grant_idx*3 +: 3];
    end
  end

  alu u_alu (
    .a_i      (alu_a),
    .b_i      (alu_b),
    .op_i     (alu_op),
    .result_o (alu_result),
    .zero_o   (alu_zero)
  );

  // Pointer moves just past the winner; stays put when nobody is accepted.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept_any) begin
      rr_ptr_d = (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (!rst_n) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slot
    logic              vld_q;
    logic [DATA_W-1:0] res_q;
    logic              zero_q;

    // Load on accept (even while draining), clear on consume, else hold data.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        vld_q  <= 1'b0;
        res_q  <= '0;
        zero_q <= 1'b0;
      end else if (accept[gi]) begin
        vld_q  <= 1'b1;
        res_q  <= alu_result;
        zero_q <= alu_zero;
      end else if (rsp_ready[gi]) begin
        vld_q  <= 1'b0;
      end
    end

    assign rsp_valid[gi]                   = vld_q;
    assign rsp_result[gi*DATA_W +: DATA_W] = res_q;
    assign rsp_zero[gi]                    = zero_q;
  end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Self-checking bench for alu_rr_arbiter with N_REQ=2: directed scenarios
// followed by constrained-random traffic against a behavioural model.
module tb_alu_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req_valid = '0;
  logic [1:0] req_ready;
  logic [7:0] req_a = '0;
  logic [7:0] req_b = '0;
  logic [5:0] req_op = '0;
  logic [1:0] rsp_valid;
  logic [1:0] rsp_ready = '0;
  logic [7:0] rsp_result;
  logic [1:0] rsp_zero;

  int total = 0;
  int bad   = 0;

  // Behavioural model state: slot contents and the next index to favour.
  bit       m_vld [2];
  bit [3:0] m_res [2];
  bit       m_zero[2];
  int       m_ptr;
  logic [1:0] last_grant;

  always #5 clk = ~clk;

  alu_rr_arbiter #(.N_REQ(2), .DATA_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero)
  );

  function automatic bit [3:0] ref_alu(input int a, input int b, input int op);
    int r;
    case (op)
      0:       r = a + b;
      1:       r = a - b + 16;
      2:       r = a & b;
      3:       r = a | b;
      default: r = 0;
    endcase
    return 4'(r % 16);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive on the falling edge, check just after, then advance the model.
  task automatic cycle(input logic [1:0] v, input logic [7:0] a, input logic [7:0] b,
                       input logic [5:0] op, input logic [1:0] rr, input logic rn);
    logic [1:0] eg;
    int p;
    int win;
    @(negedge clk);
    req_valid = v;
    req_a     = a;
    req_b     = b;
    req_op    = op;
    rsp_ready = rr;
    rst_n     = rn;
    #1;
    eg  = '0;
    win = -1;
    if (rn) begin
      for (int k = 0; k < 2; k++) begin
        p = (m_ptr + k) % 2;
        if (win < 0 && v[p] && (!m_vld[p] || rr[p])) win = p;
      end
    end
    if (win >= 0) eg[win] = 1'b1;
    chk("req_ready", req_ready, eg);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rsp_valid%0d", i), rsp_valid[i], m_vld[i]);
      chk($sformatf("rsp_result%0d", i), rsp_result[i*4 +: 4], m_res[i]);
      chk($sformatf("rsp_zero%0d", i), rsp_zero[i], m_zero[i]);
    end
    $display("cyc rst_n=%0b valid=%b rsp_ready=%b ready=%b rsp_valid=%b result=%h zero=%b",
             rn, v, rr, req_ready, rsp_valid, rsp_result, rsp_zero);
    last_grant = req_ready;
    if (!rn) begin
      for (int i = 0; i < 2; i++) begin
        m_vld[i] = 0; m_res[i] = 0; m_zero[i] = 0;
      end
      m_ptr = 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (i == win) begin
          m_vld[i]  = 1;
          m_res[i]  = ref_alu(int'(a[i*4 +: 4]), int'(b[i*4 +: 4]), int'(op[i*3 +: 3]));
          m_zero[i] = (m_res[i] == 0);
        end else if (rr[i]) begin
          m_vld[i] = 0;
        end
      end
      if (win >= 0) m_ptr = (win + 1) % 2;
    end
  endtask

  initial begin
    logic [1:0] pv;
    logic [7:0] pa;
    logic [7:0] pb;
    logic [5:0] po;
    m_ptr = 0;
    for (int i = 0; i < 2; i++) begin
      m_vld[i] = 0; m_res[i] = 0; m_zero[i] = 0;
    end

    // Reset held two cycles with both requesting: nothing granted, slots empty.
    cycle(2'b11, 8'h57, 8'h53, 6'o10, 2'b11, 1'b0);
    chk("rst_ready_a", req_ready, 2'b00);
    cycle(2'b11, 8'h57, 8'h53, 6'o10, 2'b11, 1'b0);
    chk("rst_ready_b", req_ready, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 2'b00);

    // First cycle after release: requester 0 wins (req0 ADD 7,3; req1 SUB 5,5).
    cycle(2'b11, 8'h57, 8'h53, 6'o10, 2'b11, 1'b1);
    chk("grant_after_rst", last_grant, 2'b01);
    cycle(2'b10, 8'h57, 8'h53, 6'o10, 2'b11, 1'b1);
    chk("single_grant1", last_grant, 2'b10);
    chk("add_7_3_valid", rsp_valid[0], 1'b1);
    chk("add_7_3_result", rsp_result[3:0], 4'hA);
    chk("add_7_3_zero", rsp_zero[0], 1'b0);
    cycle(2'b00, 8'h00, 8'h00, 6'o00, 2'b11, 1'b1);
    chk("single_drained", rsp_valid[0], 1'b0);
    chk("sub_5_5_result", rsp_result[7:4], 4'h0);
    chk("sub_5_5_zero", rsp_zero[1], 1'b1);

    // Contention: both always valid, both consuming -> 0,1,0,1.
    cycle(2'b11, 8'h12, 8'h34, 6'o23, 2'b11, 1'b1);
    chk("contend_0", last_grant, 2'b01);
    cycle(2'b11, 8'h56, 8'h78, 6'o01, 2'b11, 1'b1);
    chk("contend_1", last_grant, 2'b10);
    cycle(2'b11, 8'h9A, 8'hBC, 6'o32, 2'b11, 1'b1);
    chk("contend_2", last_grant, 2'b01);
    cycle(2'b11, 8'hDE, 8'hF0, 6'o10, 2'b11, 1'b1);
    chk("contend_3", last_grant, 2'b10);

    // Backpressure: slot 0 loaded with OR 1,2 = 3 and left unconsumed.
    cycle(2'b01, 8'h01, 8'h02, 6'o03, 2'b10, 1'b1);
    chk("bp_load", last_grant, 2'b01);
    for (int c = 0; c < 5; c++) begin
      cycle(2'b11, 8'h41, 8'h22, 6'o03, 2'b10, 1'b1);
      chk("bp_ready", last_grant, 2'b10);
      chk("bp_hold", rsp_result[3:0], 4'h3);
    end

    // Wrap: ADD F,1 while draining the held 3; then SUB 0,1 while draining that.
    cycle(2'b01, 8'h0F, 8'h01, 6'o00, 2'b01, 1'b1);
    chk("wrap_grant", last_grant, 2'b01);
    cycle(2'b01, 8'h00, 8'h01, 6'o01, 2'b01, 1'b1);
    chk("wrap_add_valid", rsp_valid[0], 1'b1);
    chk("wrap_add_result", rsp_result[3:0], 4'h0);
    chk("wrap_add_zero", rsp_zero[0], 1'b1);
    chk("wrap_sub_grant", last_grant, 2'b01);
    cycle(2'b00, 8'h00, 8'h00, 6'o00, 2'b00, 1'b1);
    chk("wrap_sub_valid", rsp_valid[0], 1'b1);
    chk("wrap_sub_result", rsp_result[3:0], 4'hF);
    chk("wrap_sub_zero", rsp_zero[0], 1'b0);
    cycle(2'b00, 8'h00, 8'h00, 6'o00, 2'b11, 1'b1);

    // Mid-op reset: accept req1 AND C,A, then reset at the following edge.
    cycle(2'b10, 8'hC0, 8'hA0, 6'o20, 2'b11, 1'b1);
    chk("midrst_accept", last_grant, 2'b10);
    cycle(2'b00, 8'h00, 8'h00, 6'o00, 2'b00, 1'b0);
    cycle(2'b00, 8'h00, 8'h00, 6'o00, 2'b00, 1'b1);
    chk("midrst_valid", rsp_valid, 2'b00);
    chk("midrst_result", rsp_result[7:4], 4'h0);

    // Random traffic; each requester holds its request until accepted.
    pv = '0; pa = '0; pb = '0; po = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pv[i] && $urandom_range(0, 2) != 0) begin
          pv[i]         = 1'b1;
          pa[i*4 +: 4]  = 4'($urandom);
          pb[i*4 +: 4]  = 4'($urandom);
          po[i*3 +: 3]  = 3'($urandom);
        end
      end
      cycle(pv, pa, pb, po, 2'($urandom), ($urandom_range(0, 39) != 0));
      pv = pv & ~last_grant;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
